// File: rtl/io_port_pkg.sv
// Shared constants and types for the quasi-bidirectional I/O port bank.
package io_port_pkg;

    // Width of the port index on the data-bus side; it allows up to eight ports.
    localparam int SEL_W     = 3;
    localparam int MAX_PORTS = 1 << SEL_W;

    // Read source selected by the rmw input.
    typedef enum logic {
        RD_PIN   = 1'b0,  // synchronised pin levels
        RD_LATCH = 1'b1   // output latch (read-modify-write)
    } rd_src_e;

    // Per-bit reset values. Replicate them to the port width where they are used.
    localparam logic LATCH_RST = 1'b1;
    localparam logic SYNC_RST  = 1'b1;

endpackage

// File: rtl/io_port_slice.sv
// One quasi-bidirectional port: output latch, pin synchroniser, one-cycle strong
// pull-up after a 0->1 latch transition, and sticky falling-edge flags.
module io_port_slice
    import io_port_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,      // write strobe, already qualified by sel
    input  logic             byte_mode,  // 1: whole byte, 0: bits picked by position
    input  logic [WIDTH-1:0] position,
    input  logic [WIDTH-1:0] din,
    input  logic             bin,
    input  logic             clr_en,     // flag clear strobe, already qualified by sel
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] latch,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic [WIDTH-1:0] edge_flag
);

    logic [WIDTH-1:0] latch_q;
    logic [WIDTH-1:0] latch_d;
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_sync_q;
    logic [WIDTH-1:0] flag_q;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr_mask;

    // Next latch value: a byte write or a masked bit write.
    always_comb begin
        // NOTE: the hold value is assigned first so that every path drives latch_d; a missing default would infer a latch.
        latch_d = latch_q;
        if (wr_en) begin
            if (byte_mode) begin
                latch_d = din;
            end else begin
                latch_d = (latch_q & ~position) | (position & {WIDTH{bin}});
            end
        end
    end

    // Output latch, plus a one-cycle pulse for bits that go from 0 to 1.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments, so every flop samples its pre-edge inputs.
        if (reset) begin
            latch_q <= {WIDTH{LATCH_RST}};
            pulse_q <= '0;
        end else begin
            latch_q <= latch_d;
            pulse_q <= ~latch_q & latch_d;
        end
    end

    // Pin synchroniser shift chain and the previous synchronised value.
    always_ff @(posedge clk) begin
        // NOTE: every stage of the array is reset, not only the last one. Stale low levels would otherwise produce a false falling edge after reset.
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {WIDTH{SYNC_RST}};
            end
            prev_sync_q <= {WIDTH{SYNC_RST}};
        end else begin
            sync_q[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_sync_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync     = sync_q[SYNC_STAGES-1];
    assign fall     = prev_sync_q & ~sync;
    assign clr_mask = clr_en ? din : '0;

    // Sticky edge flags. When a clear and a new edge hit the same bit in one cycle, the edge wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= '0;
        end else begin
            flag_q <= (flag_q & ~clr_mask) | fall;
        end
    end

    assign latch     = latch_q;
    assign pin_out   = latch_q;
    assign pin_oe    = ~latch_q | pulse_q;
    assign edge_flag = flag_q;

endmodule

// File: rtl/io_port_bank.sv
// Bank of NPORTS quasi-bidirectional 8051-style ports on the internal data bus.
// This module decodes the access, muxes read data and combines the edge flags into irq.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int NPORTS      = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     en,
    input  logic                     oe,
    input  logic                     Bb,
    input  logic [WIDTH-1:0]         position,
    input  logic                     rmw,
    input  logic [WIDTH-1:0]         din,
    input  logic                     bin,
    output logic [WIDTH-1:0]         dout,
    output logic                     bout,
    input  logic [NPORTS*WIDTH-1:0]  pin_in,
    output logic [NPORTS*WIDTH-1:0]  pin_out,
    output logic [NPORTS*WIDTH-1:0]  pin_oe,
    input  logic [NPORTS*WIDTH-1:0]  irq_mask,
    input  logic                     clr_en,
    output logic [NPORTS*WIDTH-1:0]  edge_flag,
    output logic                     irq
);

    logic [WIDTH-1:0] latch_arr [NPORTS];
    logic [WIDTH-1:0] sync_arr  [NPORTS];
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_bit;
    rd_src_e          rd_src;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic hit;
        assign hit = (sel == SEL_W'(p));

        io_port_slice #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (en & hit),
            .byte_mode (Bb),
            .position  (position),
            .din       (din),
            .bin       (bin),
            .clr_en    (clr_en & hit),
            .pin_in    (pin_in[p*WIDTH +: WIDTH]),
            .latch     (latch_arr[p]),
            .sync      (sync_arr[p]),
            .pin_out   (pin_out[p*WIDTH +: WIDTH]),
            .pin_oe    (pin_oe[p*WIDTH +: WIDTH]),
            .edge_flag (edge_flag[p*WIDTH +: WIDTH])
        );
    end

    assign rd_src = rd_src_e'(rmw);

    // Read mux. If sel points past the last port, nothing matches and the read returns zero.
    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (sel == SEL_W'(p)) begin
                rd_valid = 1'b1;
                rd_data  = (rd_src == RD_LATCH) ? latch_arr[p] : sync_arr[p];
            end
        end
    end

    // Bit read: the lowest set position bit wins, so scan from the top down.
    always_comb begin
        rd_bit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (position[i]) begin
                rd_bit = rd_data[i];
            end
        end
    end

    assign dout = (oe && rd_valid) ? rd_data : '0;
    assign bout = oe && rd_valid && rd_bit;
    assign irq  = |(edge_flag & irq_mask);

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed vectors, corner-case sequences,
// then randomized traffic checked against a delay-line reference model.
module tb_io_port_bank;

    localparam int NP = 4;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int N  = NP * W;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   sel;
    logic         en, oe, bb, rmw, bin, clr_en;
    logic [W-1:0] position, din;
    logic [W-1:0] dout;
    logic         bout, irq;
    logic [N-1:0] pin_in, pin_out, pin_oe, irq_mask, edge_flag;

    int tests = 0;
    int fails = 0;

    io_port_bank #(.NPORTS(NP), .WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .en        (en),
        .oe        (oe),
        .Bb        (bb),
        .position  (position),
        .rmw       (rmw),
        .din       (din),
        .bin       (bin),
        .dout      (dout),
        .bout      (bout),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .irq_mask  (irq_mask),
        .clr_en    (clr_en),
        .edge_flag (edge_flag),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. Each port holds a latch and the latch value before the last edge.
    // Pins are kept as a history of samples, so the synchronised value is the pin seen S edges ago.
    logic [W-1:0] m_latch [NP];
    logic [W-1:0] m_prev  [NP];
    logic [W-1:0] m_flag  [NP];
    logic [N-1:0] m_hist  [S+1];

    task automatic model_edge();
        logic [W-1:0] nxt, fell, clr;
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                m_latch[p] = '1; m_prev[p] = '1; m_flag[p] = '0;
            end
            for (int k = 0; k <= S; k++) m_hist[k] = '1;
        end else begin
            for (int p = 0; p < NP; p++) begin
                nxt = m_latch[p];
                if (en && int'(sel) == p) begin
                    if (bb) nxt = din;
                    else for (int i = 0; i < W; i++) if (position[i]) nxt[i] = bin;
                end
                fell = m_hist[S][p*W +: W] & ~m_hist[S-1][p*W +: W];
                clr  = (clr_en && int'(sel) == p) ? din : '0;
                m_flag[p]  = (m_flag[p] & ~clr) | fell;
                m_prev[p]  = m_latch[p];
                m_latch[p] = nxt;
            end
            for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pin_in;
        end
    endtask

    // The model steps with the DUT on every clock edge. Outputs settle 1 ns after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        logic [N-1:0] e_out, e_oe, e_flag;
        logic [W-1:0] src, e_dout;
        logic         e_bout, found;
        for (int p = 0; p < NP; p++) begin
            e_out[p*W +: W]  = m_latch[p];
            // A bit is driven while its latch is low, and for the first cycle after it goes high.
            e_oe[p*W +: W]   = ~m_latch[p] | (m_latch[p] & ~m_prev[p]);
            e_flag[p*W +: W] = m_flag[p];
        end
        src = '0;
        if (int'(sel) < NP) src = rmw ? m_latch[sel[1:0]] : m_hist[S-1][int'(sel)*W +: W];
        e_dout = (oe && int'(sel) < NP) ? src : '0;
        e_bout = 1'b0; found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!found && position[i]) begin e_bout = src[i]; found = 1'b1; end
        end
        e_bout = e_bout & oe & (int'(sel) < NP);
        check("rnd_pin_out",   pin_out,   e_out);
        check("rnd_pin_oe",    pin_oe,    e_oe);
        check("rnd_edge_flag", edge_flag, e_flag);
        check("rnd_irq",       N'(irq),   N'(|(e_flag & irq_mask)));
        check("rnd_dout",      N'(dout),  N'(e_dout));
        check("rnd_bout",      N'(bout),  N'(e_bout));
    endtask

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic       bb;
        logic [7:0] pos;
        logic       bin;
        logic [7:0] din;
        logic       rmw;
        logic       oe;
        int         port;
        logic [7:0] exp_dout;
        logic       exp_bout;
        logic [7:0] exp_oe;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Directed vectors, applied in order from reset with all pins high.
        // Fields: sel en bb pos bin din rmw oe | port exp_dout exp_bout exp_pin_oe[port]
        vecs[0]  = '{3'd1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1, 8'hFF, 1'b1, 8'h00};
        vecs[1]  = '{3'd2, 1'b1, 1'b1, 8'h02, 1'b0, 8'h5A, 1'b1, 1'b1, 2, 8'h5A, 1'b1, 8'hA5};
        vecs[2]  = '{3'd0, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0, 8'hFF};
        vecs[3]  = '{3'd0, 1'b1, 1'b1, 8'h01, 1'b0, 8'h01, 1'b1, 1'b1, 0, 8'h01, 1'b1, 8'hFF};
        vecs[4]  = '{3'd0, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h01, 1'b1, 8'hFE};
        vecs[5]  = '{3'd3, 1'b1, 1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b1, 3, 8'hF7, 1'b0, 8'h08};
        vecs[6]  = '{3'd3, 1'b0, 1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 3, 8'hFF, 1'b1, 8'h08};
        vecs[7]  = '{3'd5, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b0, 8'h00};
        vecs[8]  = '{3'd1, 1'b0, 1'b1, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1, 8'hFF, 1'b1, 8'h00};
        vecs[9]  = '{3'd2, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h00, 1'b0, 8'hA5};
        vecs[10] = '{3'd0, 1'b1, 1'b0, 8'h24, 1'b1, 8'h00, 1'b1, 1'b1, 0, 8'h25, 1'b1, 8'hFE};
        vecs[11] = '{3'd0, 1'b0, 1'b0, 8'h24, 1'b1, 8'h00, 1'b1, 1'b1, 0, 8'h25, 1'b1, 8'hDA};

        reset = 1'b1; sel = '0; en = 0; oe = 0; bb = 1; rmw = 1; bin = 0; clr_en = 0;
        position = 8'h01; din = '0; pin_in = '1; irq_mask = '0;
        tick(); tick();
        check("reset_pin_out",   pin_out,   '1);
        check("reset_pin_oe",    pin_oe,    '0);
        check("reset_edge_flag", edge_flag, '0);
        check("reset_irq",       N'(irq),   '0);
        check("reset_dout",      N'(dout),  '0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 12; v++) begin
            sel = vecs[v].sel; en = vecs[v].en; bb = vecs[v].bb; position = vecs[v].pos;
            bin = vecs[v].bin; din = vecs[v].din; rmw = vecs[v].rmw; oe = vecs[v].oe;
            tick();
            check($sformatf("vec%0d_dout", v), N'(dout), N'(vecs[v].exp_dout));
            check($sformatf("vec%0d_bout", v), N'(bout), N'(vecs[v].exp_bout));
            check($sformatf("vec%0d_pin_oe", v), N'(pin_oe[vecs[v].port*W +: W]), N'(vecs[v].exp_oe));
        end
        en = 0;

        // Read-pin versus read-latch on port 3 (latch F7) while its pins are forced low.
        sel = 3'd3; oe = 1; rmw = 0; bb = 1; pin_in[31:24] = 8'h00;
        tick();
        check("sync_lat1_dout", N'(dout), N'(8'hFF));
        tick();
        check("sync_lat2_dout", N'(dout), N'(8'h00));
        rmw = 1; #1;
        check("rmw_latch_dout", N'(dout), N'(8'hF7));
        pin_in[31:24] = 8'hFF;
        tick(); tick(); tick();

        // Falling edge on pin 1.4 with its mask set. The flag and irq go high on the third edge.
        irq_mask = '0; irq_mask[12] = 1'b1; sel = 3'd1; oe = 0;
        pin_in[12] = 1'b0;
        tick();
        check("edge_c1_flag", N'(edge_flag[12]), '0);
        tick();
        check("edge_c2_irq", N'(irq), '0);
        tick();
        check("edge_c3_flag", N'(edge_flag[12]), N'(1'b1));
        check("edge_c3_irq",  N'(irq), N'(1'b1));
        pin_in[12] = 1'b1;
        tick(); tick(); tick();
        check("edge_rise_hold", N'(edge_flag[12]), N'(1'b1));
        // A second fall arrives on the same edge as a clear of that bit, and the set wins.
        pin_in[12] = 1'b0;
        tick(); tick();
        clr_en = 1; din = 8'h10;
        tick();
        check("set_beats_clear", N'(edge_flag[12]), N'(1'b1));
        tick();
        check("clear_flag", N'(edge_flag[12]), '0);
        check("clear_irq",  N'(irq), '0);
        clr_en = 0; pin_in[12] = 1'b1;
        tick(); tick(); tick();

        // Reset asserted during a pull-up pulse and during a pin falling through the synchroniser.
        sel = 3'd2; en = 1; bb = 1; din = 8'h00;
        tick();
        din = 8'hFF;
        tick();
        check("pulse_before_reset", N'(pin_oe[23:16]), N'(8'hFF));
        en = 0; pin_in[0] = 1'b0;
        tick();
        reset = 1;
        tick();
        check("midreset_pin_oe",    pin_oe,    '0);
        check("midreset_pin_out",   pin_out,   '1);
        check("midreset_edge_flag", edge_flag, '0);
        reset = 0; pin_in[0] = 1'b1;
        tick(); tick(); tick();
        check("post_reset_flag", edge_flag, '0);

        // Randomized traffic checked against the model.
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 63) == 0);
            sel      = 3'($urandom_range(0, 7));
            en       = ($urandom_range(0, 2) == 0);
            oe       = $urandom_range(0, 1) == 1;
            bb       = $urandom_range(0, 1) == 1;
            rmw      = $urandom_range(0, 1) == 1;
            bin      = $urandom_range(0, 1) == 1;
            clr_en   = ($urandom_range(0, 5) == 0);
            position = 8'($urandom);
            din      = 8'($urandom);
            irq_mask = N'($urandom);
            pin_in   = pin_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
